// File: rtl/hdmi_video_out.sv
// hdmi_video_out
//   Generates 720x480p60 (CEA-861 format 2) timing on video_clk. It reads the
//   160x144 2-bit-shade GameBoy framebuffer, scales it 3x to 480x432, centres
//   it in the active area and maps each shade to 24-bit RGB for the HDMI
//   transmitter.
// Ports
//   video_clk    in   pixel clock
//   rst          in   synchronous active-high reset
//   lcd_on       in   1 = show framebuffer, 0 = window shows shade 0 (no reads)
//   fb_rd        out  framebuffer read strobe (stage 0)
//   fb_addr      out  framebuffer address row*160+col; holds while fb_rd=0
//   fb_data      in   shade, valid the cycle after fb_rd
//   HDMI_TX_DE   out  data enable (active area)
//   HDMI_TX_HS   out  hsync, active-low
//   HDMI_TX_VS   out  vsync, active-low
//   HDMI_TX_D    out  pixel {R,G,B}
//   frame_start  out  pulse aligned with output pixel (0,0)
module hdmi_video_out #(
   parameter int          H_ACTIVE   = 720,
   parameter int          H_FP       = 16,
   parameter int          H_SYNC     = 62,
   parameter int          H_BP       = 60,
   parameter int          V_ACTIVE   = 480,
   parameter int          V_FP       = 9,
   parameter int          V_SYNC     = 6,
   parameter int          V_BP       = 30,
   parameter int          SCALE      = 3,
   parameter int          X_OFF      = 120,
   parameter int          Y_OFF      = 24,
   parameter logic [23:0] BORDER_RGB = 24'h000000
) (
   input  logic        video_clk,
   input  logic        rst,
   input  logic        lcd_on,
   output logic        fb_rd,
   output logic [14:0] fb_addr,
   input  logic [1:0]  fb_data,
   output logic        HDMI_TX_DE,
   output logic        HDMI_TX_HS,
   output logic        HDMI_TX_VS,
   output logic [23:0] HDMI_TX_D,
   output logic        frame_start
);

   localparam int FB_W = 160;
   localparam int FB_H = 144;

   localparam logic [9:0]  H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]  WX0    = 10'(X_OFF);
   localparam logic [9:0]  WX1    = 10'(X_OFF + FB_W * SCALE - 1);
   localparam logic [9:0]  WY0    = 10'(Y_OFF);
   localparam logic [9:0]  WY1    = 10'(Y_OFF + FB_H * SCALE - 1);
   localparam logic [1:0]  PH_LAST = 2'(SCALE - 1);
   localparam logic [14:0] ROW_STEP = 15'(FB_W);

   function automatic logic [23:0] shade_rgb(input logic [1:0] shade);
      case (shade)
         2'd0:    return 24'hE0F8D0;
         2'd1:    return 24'h88C070;
         2'd2:    return 24'h346856;
         default: return 24'h081820;
      endcase
   endfunction

   logic [9:0]  h_q, h_d, v_q, v_d;
   logic [1:0]  x_ph_q, x_ph_d, y_ph_q, y_ph_d;
   logic [7:0]  col_q, col_d;
   logic [14:0] row_base_q, row_base_d;
   logic [14:0] addr_hold_q, addr_hold_d;

   logic        de_p0, hs_p0, vs_p0, win_p0, fs_p0, rd_p0;
   logic [14:0] addr_p0;

   logic        de_p1_q, de_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
   logic        win_p1_q, win_p1_d, lcd_p1_q, lcd_p1_d, fs_p1_q, fs_p1_d;

   logic        de_p2_q, de_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
   logic        fs_p2_q, fs_p2_d;
   logic [23:0] d_p2_q, d_p2_d;

   // ---- stage 0: raster counters, window decode, framebuffer request ----
   always_comb begin
      de_p0   = (h_q < H_ACT) && (v_q < V_ACT);
      hs_p0   = !((h_q >= HS_BEG) && (h_q <= HS_END));
      vs_p0   = !((v_q >= VS_BEG) && (v_q <= VS_END));
      win_p0  = (h_q >= WX0) && (h_q <= WX1) && (v_q >= WY0) && (v_q <= WY1);
      fs_p0   = (h_q == 10'd0) && (v_q == 10'd0);
      rd_p0   = win_p0 && lcd_on;
      addr_p0 = row_base_q + {7'd0, col_q};
      fb_rd   = rd_p0;
      fb_addr = rd_p0 ? addr_p0 : addr_hold_q;
   end

   always_comb begin
      h_d         = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
      v_d         = v_q;
      x_ph_d      = x_ph_q;
      col_d       = col_q;
      y_ph_d      = y_ph_q;
      row_base_d  = row_base_q;
      addr_hold_d = fb_addr;

      if (h_q == H_LAST)
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

      // Phase counters replace a divide-by-SCALE on the raster position.
      if (win_p0) begin
         if (x_ph_q == PH_LAST) begin
            x_ph_d = 2'd0;
            col_d  = col_q + 8'd1;
         end else begin
            x_ph_d = x_ph_q + 2'd1;
         end
      end
      if (h_q == H_LAST) begin
         x_ph_d = 2'd0;
         col_d  = 8'd0;
      end

      // The last window pixel of a line closes that source line.
      if (win_p0 && (h_q == WX1)) begin
         if (y_ph_q == PH_LAST) begin
            y_ph_d     = 2'd0;
            row_base_d = row_base_q + ROW_STEP;
         end else begin
            y_ph_d = y_ph_q + 2'd1;
         end
      end
      if ((h_q == H_LAST) && (v_q == V_LAST)) begin
         y_ph_d     = 2'd0;
         row_base_d = 15'd0;
      end
   end

   // ---- stage 1: delay controls to line up with returning fb_data ----
   always_comb begin
      de_p1_d  = de_p0;
      hs_p1_d  = hs_p0;
      vs_p1_d  = vs_p0;
      win_p1_d = win_p0;
      lcd_p1_d = rd_p0;
      fs_p1_d  = fs_p0;
   end

   // ---- stage 2: colour select into the output registers ----
   always_comb begin
      de_p2_d = de_p1_q;
      hs_p2_d = hs_p1_q;
      vs_p2_d = vs_p1_q;
      fs_p2_d = fs_p1_q;
      d_p2_d  = 24'h000000;
      if (de_p1_q) begin
         if (!win_p1_q)
            d_p2_d = BORDER_RGB;
         else
            d_p2_d = shade_rgb(lcd_p1_q ? fb_data : 2'd0);
      end
   end

   always_ff @(posedge video_clk) begin
      if (rst) begin
         h_q         <= 10'd0;
         v_q         <= 10'd0;
         x_ph_q      <= 2'd0;
         col_q       <= 8'd0;
         y_ph_q      <= 2'd0;
         row_base_q  <= 15'd0;
         addr_hold_q <= 15'd0;
         de_p1_q     <= 1'b0;
         hs_p1_q     <= 1'b1;
         vs_p1_q     <= 1'b1;
         win_p1_q    <= 1'b0;
         lcd_p1_q    <= 1'b0;
         fs_p1_q     <= 1'b0;
         de_p2_q     <= 1'b0;
         hs_p2_q     <= 1'b1;
         vs_p2_q     <= 1'b1;
         fs_p2_q     <= 1'b0;
         d_p2_q      <= 24'h000000;
      end else begin
         h_q         <= h_d;
         v_q         <= v_d;
         x_ph_q      <= x_ph_d;
         col_q       <= col_d;
         y_ph_q      <= y_ph_d;
         row_base_q  <= row_base_d;
         addr_hold_q <= addr_hold_d;
         de_p1_q     <= de_p1_d;
         hs_p1_q     <= hs_p1_d;
         vs_p1_q     <= vs_p1_d;
         win_p1_q    <= win_p1_d;
         lcd_p1_q    <= lcd_p1_d;
         fs_p1_q     <= fs_p1_d;
         de_p2_q     <= de_p2_d;
         hs_p2_q     <= hs_p2_d;
         vs_p2_q     <= vs_p2_d;
         fs_p2_q     <= fs_p2_d;
         d_p2_q      <= d_p2_d;
      end
   end

   assign HDMI_TX_DE  = de_p2_q;
   assign HDMI_TX_HS  = hs_p2_q;
   assign HDMI_TX_VS  = vs_p2_q;
   assign HDMI_TX_D   = d_p2_q;
   assign frame_start = fs_p2_q;

endmodule
